// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the accumulator datapath.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM
    } state_e;

    localparam fp32_t FP_ZERO    = '{sign: 1'b0, exp: 8'h00, man: 23'h0};
    localparam fp32_t FP_INF_POS = '{sign: 1'b0, exp: 8'hFF, man: 23'h0};

endpackage

// File: rtl/fp_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input reports 25.
module fp_lzc (
    input  logic [24:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd25;
        // Scanning upwards lets the highest set bit make the final assignment.
        for (int i = 0; i < 25; i++) begin
            if (value[i]) begin
                count = 5'(24 - i);
            end
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Four-cycle single-precision running-sum accumulator (truncating, flush-to-zero)
// fed by the product stream of the upstream multiplier.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             clr,
    output logic [31:0]      acc,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    state_e           state_q, state_d;
    fp32_t            acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    fp32_t            opb_q, opb_d;
    logic             load_q, load_d;
    logic             force_q, force_d;
    fp32_t            force_val_q, force_val_d;
    logic [23:0]      big_sig_q, big_sig_d;
    logic [23:0]      small_sig_q, small_sig_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             big_sign_q, big_sign_d;
    logic             small_sign_q, small_sign_d;
    logic [24:0]      sum_q, sum_d;
    logic             res_sign_q, res_sign_d;

    fp32_t            opa;
    logic [23:0]      sig_a, sig_b, small_raw, small_al;
    logic             a_big;
    logic [EXP_W-1:0] exp_big, exp_diff;
    logic [24:0]      sum_c;
    logic             sign_c;
    logic [4:0]       lz, norm_shift;
    logic [22:0]      norm_man;
    logic [8:0]       exp_inc;
    logic signed [9:0] exp_dec;
    fp32_t            result;

    fp_lzc u_lzc (
        .value (sum_q),
        .count (lz)
    );

    // Alignment: a load adds the operand to zero instead of the running sum.
    always_comb begin
        opa       = load_q ? FP_ZERO : acc_q;
        sig_a     = (opa.exp == '0) ? 24'd0 : {1'b1, opa.man};
        sig_b     = (opb_q.exp == '0) ? 24'd0 : {1'b1, opb_q.man};
        a_big     = (opa.exp >= opb_q.exp);
        exp_big   = a_big ? opa.exp : opb_q.exp;
        exp_diff  = a_big ? (opa.exp - opb_q.exp) : (opb_q.exp - opa.exp);
        small_raw = a_big ? sig_b : sig_a;
        small_al  = (exp_diff >= 8'd24) ? 24'd0 : (small_raw >> exp_diff);
    end

    always_comb begin
        sum_c  = '0;
        sign_c = big_sign_q;
        if (big_sign_q == small_sign_q) begin
            sum_c = {1'b0, big_sig_q} + {1'b0, small_sig_q};
        end else if (big_sig_q >= small_sig_q) begin
            sum_c = {1'b0, big_sig_q} - {1'b0, small_sig_q};
        end else begin
            sum_c  = {1'b0, small_sig_q} - {1'b0, big_sig_q};
            sign_c = small_sign_q;
        end
    end

    // Normalisation; cancellation and underflow both produce +0.
    always_comb begin
        norm_shift = lz - 5'd1;
        norm_man   = 23'(sum_q << norm_shift);
        exp_inc    = {1'b0, exp_q} + 9'd1;
        exp_dec    = $signed({2'b00, exp_q}) - $signed({5'b00000, norm_shift});
        result     = FP_ZERO;
        if (force_q) begin
            result = force_val_q;
        end else if (sum_q == '0) begin
            result = FP_ZERO;
        end else if (lz == 5'd0) begin
            if (exp_inc >= 9'(EXP_MAX)) begin
                result      = FP_INF_POS;
                result.sign = res_sign_q;
            end else begin
                result = '{sign: res_sign_q, exp: exp_inc[7:0], man: sum_q[23:1]};
            end
        end else if (exp_dec <= 10'sd0) begin
            result = FP_ZERO;
        end else begin
            result = '{sign: res_sign_q, exp: exp_dec[7:0], man: norm_man};
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        opb_d        = opb_q;
        load_d       = load_q;
        force_d      = force_q;
        force_val_d  = force_val_q;
        big_sig_d    = big_sig_q;
        small_sig_d  = small_sig_q;
        exp_d        = exp_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        sum_d        = sum_q;
        res_sign_d   = res_sign_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opb_d   = fp32_t'(in_data);
                    load_d  = clr;
                    state_d = ALIGN;
                end else if (clr) begin
                    acc_d   = FP_ZERO;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ALIGN: begin
                // An Inf addend always wins; an Inf running sum is otherwise held.
                force_d     = 1'b0;
                force_val_d = opa;
                if (opb_q.exp == 8'(EXP_MAX)) begin
                    force_d          = 1'b1;
                    force_val_d      = FP_INF_POS;
                    force_val_d.sign = opb_q.sign;
                end else if (opa.exp == 8'(EXP_MAX)) begin
                    force_d = 1'b1;
                end
                big_sig_d    = a_big ? sig_a : sig_b;
                small_sig_d  = small_al;
                exp_d        = exp_big;
                big_sign_d   = a_big ? opa.sign : opb_q.sign;
                small_sign_d = a_big ? opb_q.sign : opa.sign;
                state_d      = ADD;
            end
            ADD: begin
                sum_d      = sum_c;
                res_sign_d = sign_c;
                state_d    = NORM;
            end
            NORM: begin
                acc_d   = result;
                count_d = load_q ? CNT_W'(1)
                                 : ((&count_q) ? count_q : count_q + CNT_W'(1));
                ovf_d   = (ovf_q & ~load_q) | (result.exp == 8'(EXP_MAX));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // NOTE: staging registers are always written before the state that reads them, so they carry no reset.
    always_ff @(posedge clk) begin
        opb_q        <= opb_d;
        load_q       <= load_d;
        force_q      <= force_d;
        force_val_q  <= force_val_d;
        big_sig_q    <= big_sig_d;
        small_sig_q  <= small_sig_d;
        exp_q        <= exp_d;
        big_sign_q   <= big_sign_d;
        small_sign_q <= small_sign_d;
        sum_q        <= sum_d;
        res_sign_q   <= res_sign_d;
    end

    assign in_ready = (state_q == IDLE);
    assign acc      = acc_q;
    assign done     = done_q;
    assign count    = count_q;
    assign ovf      = ovf_q;

endmodule
